// File: rtl/m_seq_gen_pkg.sv
// Shared constants and helpers for the m-sequence generator family.
package m_seq_gen_pkg;

  localparam int unsigned N_DEFAULT = 7;

  // x^7 + x + 1 is primitive and gives the 127-step default period
  localparam logic [N_DEFAULT-1:0] POLY_N7 = 7'b0000011;

  function automatic logic parity32(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/m_seq_gen_lfsr_core.sv
// Fibonacci LFSR state with seed load, all-zero lock-up guard and sticky fault.
module lfsr_core
  import m_seq_gen_pkg::*;
#(
  parameter int unsigned     N    = N_DEFAULT,
  parameter logic [N-1:0]    POLY = N'(POLY_N7)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] state,
  output logic         fault
);

  localparam logic [N-1:0] ONES = {N{1'b1}};
  localparam logic [N-1:0] ZERO = {N{1'b0}};

  logic [N-1:0] state_q, state_d;
  logic         fault_q, fault_d;
  logic         fb_s;

  assign fb_s = parity32(32'(state_q & POLY));

  // Load beats the guard, the guard beats a step; a zero seed is never stored
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (load) begin
      if (seed == ZERO) begin
        state_d = ONES;
        fault_d = 1'b1;
      end else begin
        state_d = seed;
      end
    end else if (state_q == ZERO) begin
      state_d = ONES;
      fault_d = 1'b1;
    end else if (step) begin
      state_d = {fb_s, state_q[N-1:1]};
    end else begin
      state_d = state_q;
    end
  end

  // State and fault registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ONES;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: rtl/m_seq_gen.sv
// m-sequence generator: serial PN bit plus W-bit packed words on a valid/ready
// stream, with a wrap pulse each time the state returns to the loaded seed.
module m_seq_gen
  import m_seq_gen_pkg::*;
#(
  parameter int unsigned  N    = N_DEFAULT,
  parameter logic [N-1:0] POLY = N'(POLY_N7),
  parameter int unsigned  W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic         m_seq,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         wrap,
  output logic         fault
);

  localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [N-1:0]  ONES     = {N{1'b1}};
  localparam logic [N-1:0]  ZERO     = {N{1'b0}};

  logic [N-1:0]  state_s, nxt_s, seed_eff_s;
  logic [N-1:0]  seed_reg_q, seed_reg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  asm_q, asm_d, word_s;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          wrap_q, wrap_d;
  logic          stall_s, step_s, adv_s, last_s;

  lfsr_core #(.N(N), .POLY(POLY)) u_core (
    .clk   (clk),
    .rst   (rst),
    .step  (step_s),
    .load  (load),
    .seed  (seed),
    .state (state_s),
    .fault (fault)
  );

  // Only the step that would complete a word waits for the consumer
  assign stall_s    = (cnt_q == CNT_LAST) & out_valid_q & ~out_ready;
  assign step_s     = en & ~load & ~stall_s;
  assign adv_s      = step_s & (state_s != ZERO);
  assign last_s     = adv_s & (cnt_q == CNT_LAST);
  assign nxt_s      = {parity32(32'(state_s & POLY)), state_s[N-1:1]};
  assign seed_eff_s = (seed == ZERO) ? ONES : seed;

  // Current assembly register with the pre-step bit inserted at cnt
  always_comb begin
    word_s        = asm_q;
    word_s[cnt_q] = state_s[0];
  end

  // Packer, handshake, seed capture and wrap detection
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    seed_reg_d  = seed_reg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wrap_d      = adv_s & (nxt_s == seed_reg_q);
    if (load) begin
      cnt_d      = {CW{1'b0}};
      asm_d      = {W{1'b0}};
      seed_reg_d = seed_eff_s;
    end else if (adv_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CW{1'b0}};
        asm_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
        asm_d = word_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (last_s) begin
      out_data_d  = word_s;
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Packer and stream registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_reg_q  <= ONES;
      cnt_q       <= {CW{1'b0}};
      asm_q       <= {W{1'b0}};
      out_data_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      seed_reg_q  <= seed_reg_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign m_seq     = state_s[0];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_m_seq_gen.sv
// Bench for m_seq_gen: vector table and directed corners on N=3/W=4, a
// lock-up case with a zero tap mask, and a random run of the default N=7/W=8.
module tb_m_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [2:0] seed3 = 3'd0;
  logic [6:0] seed7 = 7'd0;

  logic       m3, v3, w3, f3;
  logic [3:0] d3;
  logic       mg, vg, wg, fg;
  logic [3:0] dg;
  logic       m7, v7, w7, f7;
  logic [7:0] d7;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m_seq_gen #(.N(3), .POLY(3'b011), .W(4)) dut3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed3), .m_seq(m3),
    .out_data(d3), .out_valid(v3), .out_ready(out_ready), .wrap(w3), .fault(f3));

  m_seq_gen #(.N(3), .POLY(3'b000), .W(4)) dutg (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed3), .m_seq(mg),
    .out_data(dg), .out_valid(vg), .out_ready(out_ready), .wrap(wg), .fault(fg));

  m_seq_gen dut7 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed7), .m_seq(m7),
    .out_data(d7), .out_valid(v7), .out_ready(out_ready), .wrap(w7), .fault(f7));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; out_ready = 1'b0; seed3 = 3'd0; seed7 = 7'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en, load, rdy;
    logic [2:0] seed;
    logic       m, v;
    logic [3:0] d;
    logic       w, f;
  } vec_t;

  function automatic vec_t mk(logic e, logic l, logic r, logic [2:0] s,
                              logic m, logic v, logic [3:0] d, logic w, logic f);
    vec_t t;
    t.en = e; t.load = l; t.rdy = r; t.seed = s;
    t.m = m; t.v = v; t.d = d; t.w = w; t.f = f;
    return t;
  endfunction

  // Reference for N=7: output bits follow s[k+7] = XOR of POLY[j]*s[k+j]
  logic [6:0] poly7 = 7'h03;
  bit         hist[$];
  int         pos, nbits;
  logic [7:0] acc, pw;
  logic       pv, mf, mw;

  function automatic void model_load(logic [6:0] s);
    logic [6:0] e;
    e = (s == 7'd0) ? 7'h7f : s;
    hist.delete();
    for (int i = 0; i < 7; i++) hist.push_back(e[i]);
    pos = 0;
  endfunction

  function automatic bit seq_at(int k);
    while (hist.size() <= k) begin
      int n;
      bit b;
      n = hist.size();
      b = 1'b0;
      for (int j = 0; j < 7; j++) if (poly7[j]) b ^= hist[n-7+j];
      hist.push_back(b);
    end
    return hist[k];
  endfunction

  function automatic void model_reset();
    model_load(7'h7f);
    nbits = 0; acc = 8'd0; pv = 1'b0; pw = 8'd0; mf = 1'b0; mw = 1'b0;
  endfunction

  function automatic void model_step(logic e, logic l, logic [6:0] s, logic r);
    logic stall, stp, done;
    stall = (nbits == 7) && pv && !r;
    stp   = e && !l && !stall;
    mw    = 1'b0;
    done  = 1'b0;
    if (l) begin
      if (s == 7'd0) mf = 1'b1;
      model_load(s);
      nbits = 0;
      acc = 8'd0;
    end else if (stp) begin
      acc[nbits] = seq_at(pos);
      pos++;
      nbits++;
      mw = (pos % 127 == 0);
      done = (nbits == 8);
    end
    if (done) begin
      pw = acc; pv = 1'b1; nbits = 0; acc = 8'd0;
    end else if (pv && r) begin
      pv = 1'b0;
    end
  endfunction

  vec_t       vt[17];
  logic [6:0] ld_exp;
  int         nw, wfirst, wsecond;

  initial begin
    // s = 1,1,1,0,0,1,0 repeating; words 0x7, 0xA, 0x3
    vt[0]  = mk(1, 0, 1, 3'd0, 1, 0, 4'h0, 0, 0);
    vt[1]  = mk(1, 0, 1, 3'd0, 1, 0, 4'h0, 0, 0);
    vt[2]  = mk(1, 0, 1, 3'd0, 0, 0, 4'h0, 0, 0);
    vt[3]  = mk(1, 0, 1, 3'd0, 0, 1, 4'h7, 0, 0);
    vt[4]  = mk(1, 0, 1, 3'd0, 1, 0, 4'h7, 0, 0);
    vt[5]  = mk(1, 0, 1, 3'd0, 0, 0, 4'h7, 0, 0);
    vt[6]  = mk(1, 0, 1, 3'd0, 1, 0, 4'h7, 1, 0);
    vt[7]  = mk(1, 0, 1, 3'd0, 1, 1, 4'hA, 0, 0);
    vt[8]  = mk(1, 0, 1, 3'd0, 1, 0, 4'hA, 0, 0);
    vt[9]  = mk(1, 0, 1, 3'd0, 0, 0, 4'hA, 0, 0);
    vt[10] = mk(1, 0, 1, 3'd0, 0, 0, 4'hA, 0, 0);
    vt[11] = mk(1, 0, 1, 3'd0, 1, 1, 4'h3, 0, 0);
    vt[12] = mk(1, 0, 1, 3'd0, 0, 0, 4'h3, 0, 0);
    vt[13] = mk(1, 0, 1, 3'd0, 1, 0, 4'h3, 1, 0);
    vt[14] = mk(0, 0, 1, 3'd0, 1, 0, 4'h3, 0, 0);
    vt[15] = mk(0, 0, 1, 3'd0, 1, 0, 4'h3, 0, 0);
    vt[16] = mk(0, 1, 1, 3'b010, 0, 0, 4'h3, 0, 0);

    do_reset();
    chk("rst_m3", m3, 1); chk("rst_v3", v3, 0); chk("rst_d3", d3, 0);
    chk("rst_w3", w3, 0); chk("rst_f3", f3, 0);
    chk("rst_m7", m7, 1); chk("rst_v7", v7, 0); chk("rst_d7", d7, 0);

    for (int i = 0; i < 17; i++) begin
      en = vt[i].en; load = vt[i].load; out_ready = vt[i].rdy; seed3 = vt[i].seed;
      tick();
      chk($sformatf("vec%0d_m", i), m3, vt[i].m);
      chk($sformatf("vec%0d_v", i), v3, vt[i].v);
      chk($sformatf("vec%0d_d", i), d3, vt[i].d);
      chk($sformatf("vec%0d_w", i), w3, vt[i].w);
      chk($sformatf("vec%0d_f", i), f3, vt[i].f);
    end
    load = 1'b0;

    // Lock-up guard: zero taps shift the state to zero after three steps
    do_reset();
    en = 1'b1;
    tick(); tick(); tick();
    chk("guard_zero_m", mg, 0); chk("guard_zero_f", fg, 0);
    tick();
    chk("guard_reload_m", mg, 1); chk("guard_reload_f", fg, 1);
    chk("guard_no_word", vg, 0);

    // Backpressure: word 0x7 held, then bits 0,1,0 and a stall
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) begin chk("bp_v4", v3, 1); chk("bp_d4", d3, 4'h7); end
    end
    chk("bp_hold_m", m3, 1); chk("bp_hold_v", v3, 1); chk("bp_hold_d", d3, 4'h7);
    out_ready = 1'b1;
    tick();
    chk("bp_next_v", v3, 1); chk("bp_next_d", d3, 4'hA); chk("bp_next_m", m3, 1);

    // Zero seed load keeps the pending word and sets sticky fault
    out_ready = 1'b0; en = 1'b0; load = 1'b1; seed3 = 3'd0;
    tick();
    chk("ld0_f", f3, 1); chk("ld0_m", m3, 1); chk("ld0_w", w3, 0);
    chk("ld0_v", v3, 1); chk("ld0_d", d3, 4'hA);
    load = 1'b0; en = 1'b1;
    tick(); tick();
    chk("ld0_sticky", f3, 1);

    // Load beats en; seed 100 gives 0,0,1,0,1,1,1 and wraps on step 7
    do_reset();
    en = 1'b1; load = 1'b1; seed3 = 3'b100; out_ready = 1'b1;
    tick();
    chk("lden_m0", m3, 0); chk("lden_w0", w3, 0); chk("lden_f0", f3, 0);
    load = 1'b0;
    ld_exp = 7'b0111010;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("lden_m%0d", k), m3, ld_exp[k-1]);
      chk($sformatf("lden_w%0d", k), w3, (k == 7) ? 1 : 0);
    end

    // Default N=7 free run: wrap every 127 steps, guard never fires
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    nw = 0; wfirst = -1; wsecond = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (w7) begin
        nw++;
        if (nw == 1) wfirst = i;
        if (nw == 2) wsecond = i;
      end
    end
    chk("p7_count", nw, 2); chk("p7_first", wfirst, 127); chk("p7_second", wsecond, 254);
    chk("p7_fault", f7, 0);

    // Random stimulus on N=7/W=8 against the sequence model
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 5);
      load      = ($urandom_range(0, 99) < 2);
      seed7     = 7'($urandom_range(0, 127));
      if (load && $urandom_range(0, 5) == 0) seed7 = 7'd0;
      model_step(en, load, seed7, out_ready);
      tick();
      chk("rnd_m", m7, seq_at(pos));
      chk("rnd_v", v7, pv);
      chk("rnd_d", d7, pw);
      chk("rnd_w", w7, mw);
      chk("rnd_f", f7, mf);
    end

    // Reset mid-word and mid-handshake clears outputs at once
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_v", v3, 1);
    rst = 1'b1;
    #1;
    chk("async_m3", m3, 1); chk("async_v3", v3, 0); chk("async_d3", d3, 0);
    chk("async_w3", w3, 0); chk("async_f3", f3, 0);
    chk("async_v7", v7, 0); chk("async_d7", d7, 0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    tick();
    chk("post_rst_v", v3, 0); chk("post_rst_m", m3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
